// File: rtl/forward_registered_pipe.sv
// Forward-registered valid/data pipeline slice; ready path stays combinational.
// Optional synchronous flush input enabled by defining FWD_PIPE_FLUSH_EN.
module forward_registered_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   localparam int CW    = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m_valid,
   input  logic [WIDTH-1:0] m_data,
   output logic             m_ready,
   output logic             s_valid,
   output logic [WIDTH-1:0] s_data,
   input  logic             s_ready,
`ifdef FWD_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   output logic [CW-1:0]    level
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  d [STAGES];
   logic [STAGES-1:0] v_in;
   logic [WIDTH-1:0]  d_in [STAGES];
   logic [STAGES-1:0] rdy;
   logic              all_v;
   logic              m_fire;
   logic              s_fire;

   // A stage may load when some stage at or after it is empty, or the sink drains.
   always_comb begin
      rdy   = '0;
      all_v = 1'b1;
      for (int i = STAGES - 1; i >= 0; i--) begin
         all_v  = all_v & v[i];
         rdy[i] = s_ready | ~all_v;
      end
   end

   always_comb begin
      v_in    = '0;
      v_in[0] = m_valid;
      d_in[0] = m_data;
      for (int i = 1; i < STAGES; i++) begin
         v_in[i] = v[i-1];
         d_in[i] = d[i-1];
      end
   end

`ifdef FWD_PIPE_FLUSH_EN
   assign m_ready = rdy[0] & ~flush;
`else
   assign m_ready = rdy[0];
`endif

   assign s_valid = v[STAGES-1];
   assign s_data  = d[STAGES-1];
   assign m_fire  = m_valid & m_ready;
   assign s_fire  = v[STAGES-1] & s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         v     <= '0;
         level <= '0;
         for (int i = 0; i < STAGES; i++) begin
            d[i] <= '0;
         end
      end
`ifdef FWD_PIPE_FLUSH_EN
      else if (flush) begin
         v     <= '0;
         level <= '0;
      end
`endif
      else begin
         for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
               v[i] <= v_in[i];
               // bubbles leave the data register untouched
               if (v_in[i]) begin
                  d[i] <= d_in[i];
               end
            end
         end
         case ({m_fire, s_fire})
            2'b10:   level <= level + ONE;
            2'b01:   level <= level - ONE;
            default: level <= level;
         endcase
      end
   end

endmodule
